// File: rtl/load_stall_ctrl.sv
// Load-use interlock: freezes PC and IF/ID, bubbles ID/EX, then runs a one-cycle MEM/WB replay window.
// Optional saturating bubble counter enabled by defining LOAD_STALL_PERF_CNT_EN.
module load_stall_ctrl #(
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       fwd_sel_a,
    input  logic [1:0]       fwd_sel_b,
    input  logic             rt_used,
    input  logic             branch_flush,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_bubble,
    output logic             stall_active,
    output logic             lmd_fwd_a,
    output logic             lmd_fwd_b,
    output logic [CNT_W-1:0] stall_count
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_STALL  = 2'd1;
    localparam logic [1:0] ST_REPLAY = 2'd2;

    localparam logic [1:0] REM_INIT = (STALL_CYCLES >= 2) ? 2'(STALL_CYCLES - 2) : 2'd0;

    logic [1:0] state_q, state_d;
    logic [1:0] rem_q, rem_d;
    logic       ha_q, ha_d;
    logic       hb_q, hb_d;
    logic       lmd_fwd_a_q, lmd_fwd_a_d;
    logic       lmd_fwd_b_q, lmd_fwd_b_d;
    logic       hit_a, hit_b, hazard, freeze;

    always_comb begin
        hit_a  = (fwd_sel_a == 2'b11);
        hit_b  = rt_used & (fwd_sel_b == 2'b11);
        hazard = hit_a | hit_b;
        // Flush wins over both a fresh hazard and an in-flight stall.
        freeze = ~branch_flush &
                 (((state_q == ST_RUN) & hazard) | (state_q == ST_STALL));

        state_d = state_q;
        rem_d   = rem_q;
        ha_d    = ha_q;
        hb_d    = hb_q;

        if (branch_flush) begin
            state_d = ST_RUN;
            rem_d   = 2'd0;
            ha_d    = 1'b0;
            hb_d    = 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (hazard) begin
                        ha_d = hit_a;
                        hb_d = hit_b;
                        if (STALL_CYCLES == 1) begin
                            state_d = ST_REPLAY;
                        end else begin
                            state_d = ST_STALL;
                            rem_d   = REM_INIT;
                        end
                    end
                end
                ST_STALL: begin
                    if (rem_q == 2'd0) begin
                        state_d = ST_REPLAY;
                    end else begin
                        rem_d = rem_q - 2'd1;
                    end
                end
                ST_REPLAY: begin
                    state_d = ST_RUN;
                    ha_d    = 1'b0;
                    hb_d    = 1'b0;
                end
                default: begin
                    state_d = ST_RUN;
                    rem_d   = 2'd0;
                    ha_d    = 1'b0;
                    hb_d    = 1'b0;
                end
            endcase
        end

        // Registered so the load-data selects appear exactly in the REPLAY cycle.
        lmd_fwd_a_d = (state_d == ST_REPLAY) & ha_d;
        lmd_fwd_b_d = (state_d == ST_REPLAY) & hb_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            rem_q       <= 2'd0;
            ha_q        <= 1'b0;
            hb_q        <= 1'b0;
            lmd_fwd_a_q <= 1'b0;
            lmd_fwd_b_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            ha_q        <= ha_d;
            hb_q        <= hb_d;
            lmd_fwd_a_q <= lmd_fwd_a_d;
            lmd_fwd_b_q <= lmd_fwd_b_d;
        end
    end

    assign pc_write     = ~freeze;
    assign if_id_write  = ~freeze;
    assign id_ex_bubble = freeze;
    assign stall_active = freeze;
    assign lmd_fwd_a    = lmd_fwd_a_q;
    assign lmd_fwd_b    = lmd_fwd_b_q;

`ifdef LOAD_STALL_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (freeze && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_load_stall_ctrl.sv
// Directed bench for load_stall_ctrl across STALL_CYCLES 1/2/3 and a 4-bit counter instance.
module tb_load_stall_ctrl;

`ifdef LOAD_STALL_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        logic        st;
        logic        la;
        logic        lb;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] sa [3];
    logic [1:0] sb [3];
    logic       rtu [3];
    logic       fl [3];
    logic       rs [3];

    logic        pcw [3];
    logic        ifw [3];
    logic        bub [3];
    logic        sta [3];
    logic        la [3];
    logic        lb [3];
    logic [3:0]  cnt0;
    logic [15:0] cnt1, cnt2;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    load_stall_ctrl #(.STALL_CYCLES(1), .CNT_W(4)) u_sc1 (
        .clk(clk), .rst(rs[0]), .fwd_sel_a(sa[0]), .fwd_sel_b(sb[0]), .rt_used(rtu[0]),
        .branch_flush(fl[0]), .pc_write(pcw[0]), .if_id_write(ifw[0]), .id_ex_bubble(bub[0]),
        .stall_active(sta[0]), .lmd_fwd_a(la[0]), .lmd_fwd_b(lb[0]), .stall_count(cnt0)
    );

    load_stall_ctrl #(.STALL_CYCLES(2), .CNT_W(16)) u_sc2 (
        .clk(clk), .rst(rs[1]), .fwd_sel_a(sa[1]), .fwd_sel_b(sb[1]), .rt_used(rtu[1]),
        .branch_flush(fl[1]), .pc_write(pcw[1]), .if_id_write(ifw[1]), .id_ex_bubble(bub[1]),
        .stall_active(sta[1]), .lmd_fwd_a(la[1]), .lmd_fwd_b(lb[1]), .stall_count(cnt1)
    );

    load_stall_ctrl #(.STALL_CYCLES(3), .CNT_W(16)) u_sc3 (
        .clk(clk), .rst(rs[2]), .fwd_sel_a(sa[2]), .fwd_sel_b(sb[2]), .rt_used(rtu[2]),
        .branch_flush(fl[2]), .pc_write(pcw[2]), .if_id_write(ifw[2]), .id_ex_bubble(bub[2]),
        .stall_active(sta[2]), .lmd_fwd_a(la[2]), .lmd_fwd_b(lb[2]), .stall_count(cnt2)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on DUT d (others idle), queue the expectation, then check it.
    task automatic step(input string tag, input int d, input logic [1:0] a, input logic [1:0] b,
                        input logic rt, input logic f, input logic r,
                        input logic e_st, input logic e_la, input logic e_lb, input int e_cnt);
        exp_t e;
        exp_t o;
        logic [15:0] c;
        for (int i = 0; i < 3; i++) begin
            sa[i] = 2'b00; sb[i] = 2'b00; rtu[i] = 1'b0; fl[i] = 1'b0; rs[i] = 1'b0;
        end
        sa[d] = a; sb[d] = b; rtu[d] = rt; fl[d] = f; rs[d] = r;
        e.st = e_st; e.la = e_la; e.lb = e_lb;
        e.cnt = CNT_ON ? 16'(e_cnt) : 16'd0;
        sb_q.push_back(e);
        #2;
        o = sb_q.pop_front();
        c = (d == 0) ? {12'd0, cnt0} : ((d == 1) ? cnt1 : cnt2);
        chk({tag, "_pc_write"},     {15'd0, pcw[d]}, {15'd0, ~o.st});
        chk({tag, "_if_id_write"},  {15'd0, ifw[d]}, {15'd0, ~o.st});
        chk({tag, "_id_ex_bubble"}, {15'd0, bub[d]}, {15'd0, o.st});
        chk({tag, "_stall_active"}, {15'd0, sta[d]}, {15'd0, o.st});
        chk({tag, "_lmd_fwd_a"},    {15'd0, la[d]},  {15'd0, o.la});
        chk({tag, "_lmd_fwd_b"},    {15'd0, lb[d]},  {15'd0, o.lb});
        chk({tag, "_stall_count"},  c, o.cnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e;
        for (int i = 0; i < 3; i++) begin
            sa[i] = 2'b00; sb[i] = 2'b00; rtu[i] = 1'b0; fl[i] = 1'b0; rs[i] = 1'b1;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;

        // STALL_CYCLES=1: idle after reset
        for (int i = 0; i < 5; i++) step("idle", 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step("haz_a",       0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        step("replay_a",    0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        step("run_a",       0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        step("haz_a2",      0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        step("replay_ign",  0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2);
        step("b2b_ab",      0, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
        step("replay_ab",   0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3);
        step("run_ab",      0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);

        // STALL_CYCLES=3 on rt
        step("sc3_c0",      2, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        step("sc3_c1",      2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        step("sc3_c2",      2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2);
        step("sc3_replay",  2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        step("sc3_run",     2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        step("sc3_rt_off",  2, 2'b00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        step("sc3_rt_off2", 2, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);

        // STALL_CYCLES=2: flush and reset interactions
        step("sc2_haz",     1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        step("sc2_flush",   1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        step("sc2_norep",   1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        step("sc2_norep2",  1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        step("sc2_hz_fl",   1, 2'b11, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        step("sc2_dropped", 1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        step("sc2_haz2",    1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        step("sc2_rst",     1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        step("sc2_postrst", 1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // CNT_W=4 saturation over 20 isolated hazards
        e = 3;
        for (int i = 0; i < 20; i++) begin
            step("sat_haz", 0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, e);
            e = (e < 15) ? e + 1 : 15;
            step("sat_rep", 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, e);
        end
        step("sat_hold",    0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
